// File: rtl/z180_bus_master_pkg.sv
// rtl/z180_bus_master_pkg.sv - shared state type and bus widths for the Z180 bus master
package z180_bus_master_pkg;

   localparam int ADDR_W = 20;
   localparam int DATA_W = 8;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      GRANT,
      T1,
      T2,
      T3,
      NEXT,
      REL
   } state_t;

endpackage

// File: rtl/z180_busack_sync.sv
// rtl/z180_busack_sync.sv - two-flop synchroniser for the CPU /BUSACK input
module z180_busack_sync (
   input  logic phi,
   input  logic reset_n,
   input  logic busack_n,
   output logic busack_n_sync
);

   logic meta;

   // Resets to "not acknowledged" so a fresh command always waits for a real grant
   always_ff @(posedge phi or negedge reset_n) begin
      if (!reset_n) begin
         meta          <= 1'b1;
         busack_n_sync <= 1'b1;
      end else begin
         meta          <= busack_n;
         busack_n_sync <= meta;
      end
   end

endmodule

// File: rtl/z180_bus_master.sv
// rtl/z180_bus_master.sv - Z8S180 bus initiator running byte SRAM cycles after a /BUSREQ grant
module z180_bus_master
   import z180_bus_master_pkg::*;
#(
   parameter int WAIT_STATES = 1,
   parameter int TURNAROUND  = 1
) (
   input  logic              phi,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [15:0]       cmd_len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              done,
   output logic              busy,
   output logic              busreq_n,
   input  logic              busack_n,
   output logic              bus_oe,
   output logic [ADDR_W-1:0] a_out,
   output logic              mreq_n_out,
   output logic              rd_n_out,
   output logic              wr_n_out,
   output logic              d_oe,
   output logic [DATA_W-1:0] d_out,
   input  logic [DATA_W-1:0] d_in
);

   state_t            state;
   state_t            state_next;
   logic              busack_sync;
   logic              wr_mode;
   logic [ADDR_W-1:0] addr;
   logic [15:0]       remaining;
   logic [1:0]        tcnt;
   logic [1:0]        rel_tcnt;
   logic [2:0]        wcnt;
   logic              owned;

   z180_busack_sync u_busack_sync (
      .phi           (phi),
      .reset_n       (reset_n),
      .busack_n      (busack_n),
      .busack_n_sync (busack_sync)
   );

   assign owned = (state == GRANT) || (state == T1) || (state == T2) ||
                  (state == T3) || (state == NEXT);

   always_comb begin
      state_next = state;
      wr_ready   = 1'b0;
      rel_tcnt   = 2'd0;
      case (state)
         IDLE:  if (cmd_valid) state_next = (cmd_len == 16'd0) ? REL : REQ;
         REQ:   if (!busack_sync) state_next = GRANT;
         GRANT: begin
            if (tcnt == 2'd0 && (!wr_mode || wr_valid)) begin
               state_next = T1;
               wr_ready   = wr_mode;
            end
         end
         T1:    state_next = T2;
         T2:    if (wcnt == 3'd0) state_next = T3;
         T3:    state_next = NEXT;
         NEXT: begin
            if (remaining == 16'd1) begin
               state_next = REL;
               rel_tcnt   = 2'(TURNAROUND);
            end else if (!wr_mode || wr_valid) begin
               state_next = T1;
               wr_ready   = wr_mode;
            end else begin
               state_next = GRANT;
            end
         end
         REL:   if (tcnt == 2'd0) state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // CPU took the bus back under us: drop everything and report completion
      if (owned && busack_sync) begin
         state_next = REL;
         wr_ready   = 1'b0;
         rel_tcnt   = 2'd0;
      end
   end

   always_ff @(posedge phi or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_mode   <= 1'b0;
         addr      <= '0;
         remaining <= '0;
         tcnt      <= '0;
         wcnt      <= '0;
         d_out     <= '0;
         rd_data   <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && cmd_valid) begin
            wr_mode   <= cmd_write;
            addr      <= cmd_addr;
            remaining <= cmd_len;
         end
         if (state == REQ && state_next == GRANT)
            tcnt <= 2'(TURNAROUND - 1);
         else if (state_next == REL && state != REL)
            tcnt <= rel_tcnt;
         else if (tcnt != 2'd0)
            tcnt <= tcnt - 2'd1;
         if (state == T1)
            wcnt <= 3'(WAIT_STATES);
         else if (state == T2 && wcnt != 3'd0)
            wcnt <= wcnt - 3'd1;
         if (state == T3 && !wr_mode)
            rd_data <= d_in;
         if (state == NEXT) begin
            addr      <= addr + 20'd1;
            remaining <= remaining - 16'd1;
         end
         if (wr_ready)
            d_out <= wr_data;
      end
   end

   // Pin controls decode straight from state so an async reset releases them at once
   assign cmd_ready  = reset_n && (state == IDLE);
   assign busy       = (state != IDLE);
   assign done       = (state == REL) && (tcnt == 2'd0);
   assign busreq_n   = !(owned || (state == REQ) || (state == REL && tcnt != 2'd0));
   assign bus_oe     = owned;
   assign a_out      = addr;
   assign mreq_n_out = !((state == T1) || (state == T2));
   assign rd_n_out   = !((state == T2) && !wr_mode);
   assign wr_n_out   = !((state == T2) && wr_mode);
   assign d_oe       = wr_mode && ((state == T1) || (state == T2) || (state == T3));
   assign rd_valid   = (state == NEXT) && !wr_mode;

endmodule

// File: tb/tb_z180_bus_master.sv
// tb/tb_z180_bus_master.sv - directed and randomized bench for z180_bus_master
module tb_z180_bus_master;

   localparam int WS = 1;
   localparam int TA = 1;

   logic        phi = 1'b0;
   logic        reset_n = 1'b0;
   logic        cmd_valid = 1'b0, cmd_write = 1'b0;
   logic [19:0] cmd_addr = '0;
   logic [15:0] cmd_len = '0;
   logic [7:0]  wr_data = '0;
   logic        wr_valid = 1'b0;
   logic        busack_n = 1'b1;
   logic        cmd_ready, wr_ready, rd_valid, done, busy, busreq_n, bus_oe;
   logic        mreq_n_out, rd_n_out, wr_n_out, d_oe;
   logic [7:0]  rd_data, d_out, d_in;
   logic [19:0] a_out;

   logic        cmd_valid3 = 1'b0;
   logic [19:0] cmd_addr3 = '0;
   logic [15:0] cmd_len3 = '0;
   logic        busack_n3 = 1'b1;
   logic        cmd_ready3, wr_ready3, rd_valid3, done3, busy3, busreq_n3, bus_oe3;
   logic        mreq_n3, rd_n3, wr_n3, d_oe3;
   logic [7:0]  rd_data3, d_out3, d_in3;
   logic [19:0] a_out3;

   logic [7:0]  mem [0:1048575];
   assign d_in  = mem[a_out];
   assign d_in3 = mem[a_out3];

   z180_bus_master #(.WAIT_STATES(WS), .TURNAROUND(TA)) u_dut (
      .phi(phi), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy),
      .busreq_n(busreq_n), .busack_n(busack_n), .bus_oe(bus_oe), .a_out(a_out),
      .mreq_n_out(mreq_n_out), .rd_n_out(rd_n_out), .wr_n_out(wr_n_out),
      .d_oe(d_oe), .d_out(d_out), .d_in(d_in)
   );

   z180_bus_master #(.WAIT_STATES(3), .TURNAROUND(2)) u_dut3 (
      .phi(phi), .reset_n(reset_n), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
      .cmd_write(1'b0), .cmd_addr(cmd_addr3), .cmd_len(cmd_len3),
      .wr_data(8'h00), .wr_valid(1'b0), .wr_ready(wr_ready3),
      .rd_data(rd_data3), .rd_valid(rd_valid3), .done(done3), .busy(busy3),
      .busreq_n(busreq_n3), .busack_n(busack_n3), .bus_oe(bus_oe3), .a_out(a_out3),
      .mreq_n_out(mreq_n3), .rd_n_out(rd_n3), .wr_n_out(wr_n3),
      .d_oe(d_oe3), .d_out(d_out3), .d_in(d_in3)
   );

   always #5 phi = ~phi;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   int cyc = 0;
   always @(posedge phi) cyc++;

   // CPU model: grants ack_delay cycles after the request, or withdraws when forced
   int ack_delay = 5;
   int ack_cnt = 0;
   bit ack_force = 1'b0;
   always @(negedge phi) begin
      if (busreq_n) begin
         ack_cnt  = 0;
         busack_n = 1'b1;
      end else if (ack_force) begin
         busack_n = 1'b1;
      end else if (ack_cnt >= ack_delay) begin
         busack_n = 1'b0;
      end else begin
         ack_cnt++;
      end
      busack_n3 = busreq_n3;
   end

   logic [7:0] wr_q[$];
   logic [7:0] tx_q[$];
   bit pop_pending = 1'b0;
   bit stall_arm = 1'b0;
   bit in_stall = 1'b0;
   int stall_cnt = 0;
   always @(posedge phi) begin
      #1;
      if (pop_pending) begin
         wr_q.delete(0);
         pop_pending = 1'b0;
         if (stall_arm) begin
            stall_arm = 1'b0;
            stall_cnt = 16;
         end
      end
      in_stall = (stall_cnt >= 1) && (stall_cnt <= 10);
      wr_valid = (wr_q.size() != 0) && (stall_cnt == 0);
      wr_data  = (wr_q.size() != 0) ? wr_q[0] : 8'h00;
      if (stall_cnt != 0) stall_cnt--;
   end

   int obs_addr[$], obs_len[$], obs_wd[$], obs_rd[$], obs_mcyc[$];
   int q3_len[$], q3_rd[$];
   int done_cnt = 0, done_cyc = 0, req_falls = 0, strobe_run = 0, run3 = 0;
   int stall_cycles = 0, stall_bad = 0;
   logic prev_mreq = 1'b1, prev_wr = 1'b1, prev_req = 1'b1;

   always @(negedge phi) begin
      check("rd_doe_overlap", 32'(d_oe & ~rd_n_out), 32'd0);
      check("strobe_without_oe", 32'(!bus_oe && !(mreq_n_out && rd_n_out && wr_n_out)), 32'd0);
      check("ws3_rd_doe_overlap", 32'(d_oe3 & ~rd_n3), 32'd0);
      if (prev_mreq && !mreq_n_out) begin
         obs_addr.push_back(int'(a_out));
         obs_mcyc.push_back(cyc);
      end
      if (!wr_n_out) begin
         mem[a_out] = d_out;
         if (prev_wr) obs_wd.push_back(int'(d_out));
      end
      if (!wr_n_out || !rd_n_out) strobe_run++;
      else if (strobe_run != 0) begin
         obs_len.push_back(strobe_run);
         strobe_run = 0;
      end
      if (rd_valid) obs_rd.push_back(int'(rd_data));
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (prev_req && !busreq_n) req_falls++;
      if (wr_ready) pop_pending = 1'b1;
      if (in_stall) begin
         stall_cycles++;
         if (busreq_n || !mreq_n_out || !wr_n_out || !bus_oe) stall_bad++;
      end
      if (!rd_n3) run3++;
      else if (run3 != 0) begin
         q3_len.push_back(run3);
         run3 = 0;
      end
      if (rd_valid3) q3_rd.push_back(int'(rd_data3));
      prev_mreq = mreq_n_out;
      prev_wr   = wr_n_out;
      prev_req  = busreq_n;
   end

   int issue_cyc = 0;

   task automatic run_cmd(input string tag, input bit wr, input logic [19:0] addr, input int len);
      int d0, r0, t;
      logic [19:0] ea;
      d0 = done_cnt;
      r0 = req_falls;
      obs_addr.delete(); obs_len.delete(); obs_wd.delete(); obs_rd.delete(); obs_mcyc.delete();
      if (wr) foreach (tx_q[i]) wr_q.push_back(tx_q[i]);
      t = 0;
      while (!cmd_ready && t < 100) begin @(posedge phi); #1; t++; end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = 16'(len);
      issue_cyc = cyc;
      @(posedge phi); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (done_cnt == d0 && t < 2000) begin @(posedge phi); #1; t++; end
      check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_busreq_falls"}, 32'(req_falls - r0), 32'(len != 0));
      check({tag, "_byte_count"}, 32'(obs_addr.size()), 32'(len));
      for (int i = 0; i < len; i++) begin
         ea = addr + 20'(i);
         check({tag, "_addr"}, 32'(obs_addr[i]), 32'(ea));
         check({tag, "_strobe_len"}, 32'(obs_len[i]), 32'(1 + WS));
         if (wr) check({tag, "_wdata"}, 32'(obs_wd[i]), 32'(tx_q[i]));
         else    check({tag, "_rdata"}, 32'(obs_rd[i]), 32'(tx_q[i]));
      end
      @(posedge phi); #1;
      check({tag, "_busreq_released"}, 32'(busreq_n), 32'd1);
      check({tag, "_bus_oe_off"}, 32'(bus_oe), 32'd0);
      check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
   endtask

   initial begin
      int t, d0;
      logic [19:0] ra;
      int rn;
      mem[20'hFFFFF] = 8'h11;
      mem[20'h00000] = 8'h22;

      #2;
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_busreq_n", 32'(busreq_n), 32'd1);
      check("rst_bus_oe", 32'(bus_oe), 32'd0);
      check("rst_d_oe", 32'(d_oe), 32'd0);
      check("rst_strobes", 32'({mreq_n_out, rd_n_out, wr_n_out}), 32'd7);
      check("rst_flags", 32'({rd_valid, done, wr_ready, busy}), 32'd0);
      check("rst_a_out", 32'(a_out), 32'd0);
      check("rst_d_out", 32'(d_out), 32'd0);
      #20 reset_n = 1'b1;
      @(posedge phi); #1;
      check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

      ack_delay = 5;
      tx_q = '{8'hA5, 8'h5A, 8'hC3};
      run_cmd("t1_write3", 1'b1, 20'h01000, 3);
      check("t1_byte_period_a", 32'(obs_mcyc[1] - obs_mcyc[0]), 32'(4 + WS));
      check("t1_byte_period_b", 32'(obs_mcyc[2] - obs_mcyc[1]), 32'(4 + WS));

      ack_delay = 2;
      tx_q = '{8'h11, 8'h22};
      run_cmd("t2_read_wrap", 1'b0, 20'hFFFFF, 2);

      ack_delay = 4;
      stall_cycles = 0; stall_bad = 0; stall_arm = 1'b1;
      tx_q = '{8'h77, 8'h88};
      run_cmd("t3_stall", 1'b1, 20'h04000, 2);
      check("t3_stall_cycles", 32'(stall_cycles), 32'd10);
      check("t3_stall_bus_held", 32'(stall_bad), 32'd0);
      check("t3_byte2_after_valid", 32'(obs_mcyc[1] - obs_mcyc[0]), 32'd17);

      tx_q.delete();
      run_cmd("t4_len0", 1'b0, 20'h00123, 0);
      check("t4_done_latency", 32'(done_cyc - issue_cyc), 32'd1);

      q3_len.delete(); q3_rd.delete();
      cmd_valid3 = 1'b1; cmd_addr3 = 20'h01000; cmd_len3 = 16'd2;
      @(posedge phi); #1;
      cmd_valid3 = 1'b0;
      t = 0;
      while (!done3 && t < 500) begin @(negedge phi); t++; end
      check("t6_done", 32'(done3), 32'd1);
      check("t6_rd_runs", 32'(q3_len.size()), 32'd2);
      check("t6_rd_len0", 32'(q3_len[0]), 32'd4);
      check("t6_rd_len1", 32'(q3_len[1]), 32'd4);
      check("t6_rdata0", 32'(q3_rd[0]), 32'hA5);
      check("t6_rdata1", 32'(q3_rd[1]), 32'h5A);
      @(posedge phi); #1;

      ack_delay = 3;
      d0 = done_cnt;
      obs_rd.delete();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 20'h01000; cmd_len = 16'd8;
      @(posedge phi); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (obs_rd.size() == 0 && t < 200) begin @(negedge phi); t++; end
      ack_force = 1'b1;
      t = 0;
      while (done_cnt == d0 && t < 50) begin @(negedge phi); t++; end
      check("abort_done", 32'(done_cnt - d0), 32'd1);
      check("abort_short", 32'(obs_rd.size() < 8), 32'd1);
      check("abort_first_byte", 32'(obs_rd[0]), 32'hA5);
      check("abort_busreq_n", 32'(busreq_n), 32'd1);
      @(negedge phi);
      check("abort_bus_oe", 32'(bus_oe), 32'd0);
      check("abort_idle", 32'(cmd_ready), 32'd1);
      ack_force = 1'b0;
      @(posedge phi); #1;

      ack_delay = 3;
      d0 = done_cnt;
      tx_q = '{8'h31, 8'h32, 8'h33, 8'h34};
      foreach (tx_q[i]) wr_q.push_back(tx_q[i]);
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 20'h02000; cmd_len = 16'd4;
      @(posedge phi); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (wr_n_out && t < 200) @(negedge phi) t++;
      check("t5_reached_t2", 32'(wr_n_out), 32'd0);
      #2 reset_n = 1'b0;
      #1;
      check("t5_bus_oe", 32'(bus_oe), 32'd0);
      check("t5_d_oe", 32'(d_oe), 32'd0);
      check("t5_busreq_n", 32'(busreq_n), 32'd1);
      check("t5_strobes", 32'({mreq_n_out, rd_n_out, wr_n_out}), 32'd7);
      check("t5_d_out", 32'(d_out), 32'd0);
      check("t5_cmd_ready_low", 32'(cmd_ready), 32'd0);
      wr_q.delete();
      pop_pending = 1'b0;
      repeat (3) @(posedge phi);
      #3 reset_n = 1'b1;
      @(negedge phi);
      check("t5_cmd_ready_after", 32'(cmd_ready), 32'd1);
      repeat (5) @(posedge phi);
      #1;
      check("t5_no_done", 32'(done_cnt - d0), 32'd0);

      for (int it = 0; it < 5; it++) begin
         ra = (it == 0) ? 20'hFFFFE : 20'($urandom);
         rn = $urandom_range(1, 6);
         tx_q.delete();
         for (int k = 0; k < rn; k++) tx_q.push_back(8'($urandom));
         ack_delay = $urandom_range(2, 8);
         run_cmd("rnd_write", 1'b1, ra, rn);
         ack_delay = $urandom_range(2, 8);
         run_cmd("rnd_readback", 1'b0, ra, rn);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
